// File: rtl/mat_pkg.sv
// Shared constants, row index type and FSM states for the matrix frame source.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package mat_pkg;

  localparam int MAT_ROWS   = 8;
  localparam int MAT_COLS   = 8;
  localparam int MAT_W      = 128;
  localparam int GREEN_BASE = 64;

  typedef logic [2:0] row_idx_t;

  typedef enum logic {
    ACCEPT = 1'b0,
    COMMIT = 1'b1
  } state_e;

endpackage

// File: rtl/mat_row_rotate.sv
// Rotates one 8-bit matrix row by a 3-bit column offset in either direction.
// Latency: purely combinational.
// Backpressure: none.
module mat_row_rotate
  import mat_pkg::*;
(
  input  logic [MAT_COLS-1:0] row_i,
  input  row_idx_t            off_i,
  input  logic                dir_i,
  output logic [MAT_COLS-1:0] rot_o
);

  row_idx_t src;

  // dir 0 pulls from column c+off (content slides toward column 0), dir 1 from c-off.
  always_comb begin
    rot_o = '0;
    src   = '0;
    for (int c = 0; c < MAT_COLS; c++) begin
      src      = dir_i ? (row_idx_t'(c) - off_i) : (row_idx_t'(c) + off_i);
      rot_o[c] = row_i[src];
    end
  end

endmodule

// File: rtl/mat_frame_scroller.sv
// Double-buffered 8x8 bicolour frame source with optional horizontal scrolling.
// Latency: Mat shows a committed frame two edges after the wr_last accept; Mat lags offset/dir by one cycle.
// Backpressure: wr_ready drops for the single COMMIT cycle; a held wr_valid is taken on the next cycle.
module mat_frame_scroller
  import mat_pkg::*;
#(
  parameter int STEP_TICKS = 250
) (
  input  logic             clk_1KHz,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_row,
  input  logic [7:0]       wr_red,
  input  logic [7:0]       wr_green,
  input  logic             wr_last,
  input  logic             scroll_en,
  input  logic             scroll_dir,
  output logic [MAT_W-1:0] Mat,
  output logic             commit_done
);

  localparam logic [15:0] DIV_LAST = 16'(STEP_TICKS - 1);

  state_e           state_q, state_d;
  logic [MAT_W-1:0] back_q, back_d;
  logic [MAT_W-1:0] front_q;
  logic [MAT_W-1:0] mat_q, mat_d;
  row_idx_t         off_q, off_d;
  logic [15:0]      div_q, div_d;
  logic             shown_q;
  logic             commit_done_q;
  logic             commit;

  assign commit      = (state_q == COMMIT);
  assign wr_ready    = (state_q == ACCEPT);
  assign Mat         = mat_q;
  assign commit_done = commit_done_q;

  // Write acceptance into the back buffer and the one-cycle commit handshake.
  always_comb begin
    state_d = state_q;
    back_d  = back_q;
    case (state_q)
      ACCEPT: begin
        if (wr_valid) begin
          back_d[{1'b0, wr_row, 3'b000} +: 8] = wr_red;
          back_d[{1'b1, wr_row, 3'b000} +: 8] = wr_green;
          if (wr_last) state_d = COMMIT;
        end
      end
      COMMIT:  state_d = ACCEPT;
      default: state_d = ACCEPT;
    endcase
  end

  // Step divider and scroll offset; a commit restarts both and swallows any step due.
  always_comb begin
    div_d = div_q;
    off_d = off_q;
    if (commit) begin
      div_d = '0;
      off_d = '0;
    end else if (scroll_en) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        off_d = off_q + row_idx_t'(1);
      end else begin
        div_d = div_q + 16'd1;
      end
    end else begin
      div_d = '0;
    end
  end

  // One rotator per row byte: 8 red rows then 8 green rows.
  for (genvar r = 0; r < 2 * MAT_ROWS; r++) begin : g_rot
    mat_row_rotate u_rot (
      .row_i (front_q[8*r +: 8]),
      .off_i (off_q),
      .dir_i (scroll_dir),
      .rot_o (mat_d[8*r +: 8])
    );
  end

  // State, buffers, scroll counters and the registered output frame.
  always_ff @(posedge clk_1KHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ACCEPT;
      back_q        <= '0;
      front_q       <= '0;
      mat_q         <= '0;
      off_q         <= '0;
      div_q         <= '0;
      shown_q       <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      back_q        <= back_d;
      if (commit) front_q <= back_q;
      mat_q         <= mat_d;
      off_q         <= off_d;
      div_q         <= div_d;
      shown_q       <= commit;
      commit_done_q <= shown_q;
    end
  end

endmodule

// File: tb/tb_mat_frame_scroller.sv
module tb_mat_frame_scroller;

  localparam int NDUT = 3;
  localparam int TK [NDUT] = '{4, 3, 1};

  logic         clk_1KHz = 1'b0;
  logic         rst_n    = 1'b0;
  logic         wr_valid = 1'b0;
  logic [2:0]   wr_row   = '0;
  logic [7:0]   wr_red   = '0;
  logic [7:0]   wr_green = '0;
  logic         wr_last  = 1'b0;
  logic         scroll_en  = 1'b0;
  logic         scroll_dir = 1'b0;

  logic [127:0] mat_w  [NDUT];
  logic         rdy_w  [NDUT];
  logic         done_w [NDUT];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_1KHz = ~clk_1KHz;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mat_frame_scroller #(.STEP_TICKS(TK[g])) u_dut (
      .clk_1KHz    (clk_1KHz),
      .rst_n       (rst_n),
      .wr_valid    (wr_valid),
      .wr_ready    (rdy_w[g]),
      .wr_row      (wr_row),
      .wr_red      (wr_red),
      .wr_green    (wr_green),
      .wr_last     (wr_last),
      .scroll_en   (scroll_en),
      .scroll_dir  (scroll_dir),
      .Mat         (mat_w[g]),
      .commit_done (done_w[g])
    );
  end

  // ---------------- reference model ----------------
  logic [127:0] m_back   = '0;
  logic [127:0] m_front  = '0;
  int           m_off [NDUT];
  int           m_div [NDUT];
  bit           m_inc    = 1'b0;  // a commit happens at the next edge
  bit           m_flag   = 1'b0;  // front was just replaced
  logic [127:0] exp_mat [NDUT];
  logic         exp_done = 1'b0;

  function automatic logic [127:0] view(input logic [127:0] f, input int off, input logic dir);
    logic [127:0] o;
    int src;
    o = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++) begin
        src = dir ? (c - off + 8) % 8 : (c + off) % 8;
        o[8*r + c] = f[8*r + src];
      end
    return o;
  endfunction

  always @(posedge clk_1KHz or negedge rst_n) begin
    if (!rst_n) begin
      m_back = '0; m_front = '0; m_inc = 0; m_flag = 0; exp_done = 0;
      for (int k = 0; k < NDUT; k++) begin
        m_off[k] = 0; m_div[k] = 0; exp_mat[k] = '0;
      end
    end else begin
      for (int k = 0; k < NDUT; k++) exp_mat[k] = view(m_front, m_off[k], scroll_dir);
      exp_done = m_flag;
      m_flag   = m_inc;
      if (m_inc) begin
        m_front = m_back;
        m_inc   = 0;
        for (int k = 0; k < NDUT; k++) begin m_off[k] = 0; m_div[k] = 0; end
      end else begin
        if (wr_valid) begin
          m_back[8*wr_row +: 8]      = wr_red;
          m_back[64 + 8*wr_row +: 8] = wr_green;
          if (wr_last) m_inc = 1;
        end
        for (int k = 0; k < NDUT; k++) begin
          if (scroll_en) begin
            m_div[k]++;
            if (m_div[k] == TK[k]) begin
              m_div[k] = 0;
              m_off[k] = (m_off[k] + 1) % 8;
            end
          end else begin
            m_div[k] = 0;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("mat[%0d]", k),  mat_w[k],  exp_mat[k]);
      check($sformatf("rdy[%0d]", k),  128'(rdy_w[k]),  128'(!m_inc));
      check($sformatf("done[%0d]", k), 128'(done_w[k]), 128'(exp_done));
    end
  endtask

  task automatic tick();
    @(posedge clk_1KHz);
    @(negedge clk_1KHz);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] r, input logic [7:0] rd, input logic [7:0] gr,
                    input logic l, output int n);
    bit acc;
    acc = 0; n = 0;
    wr_valid = 1; wr_row = r; wr_red = rd; wr_green = gr; wr_last = l;
    while (!acc && n < 8) begin
      acc = rdy_w[0];
      tick();
      n++;
    end
    if (!acc) check("wr_accept_timeout", 128'(acc), 128'(1));
    wr_valid = 0; wr_last = 0;
  endtask

  int nw;

  initial begin
    // reset state
    repeat (2) @(negedge clk_1KHz);
    for (int k = 0; k < NDUT; k++) begin
      check("reset_mat",  mat_w[k], 128'(0));
      check("reset_rdy",  128'(rdy_w[k]), 128'(1));
      check("reset_done", 128'(done_w[k]), 128'(0));
    end
    rst_n = 1;
    tick();

    // diagonal frame, no scrolling
    for (int r = 0; r < 8; r++) wr(3'(r), 8'(1 << r), 8'h00, r == 7, nw);
    check("commit_rdy_low", 128'(rdy_w[0]), 128'(0));
    tick();
    tick();
    check("diag_red",   {64'h0, mat_w[0][63:0]}, {64'h0, 64'h8040201008040201});
    check("diag_green", {64'h0, mat_w[0][127:64]}, 128'(0));
    check("diag_done",  128'(done_w[0]), 128'(1));
    tick();
    check("diag_done_once", 128'(done_w[0]), 128'(0));

    // single dot in row 0, scroll left then right, then hold
    for (int r = 0; r < 8; r++) wr(3'(r), (r == 0) ? 8'h01 : 8'h00, 8'h00, r == 7, nw);
    ticks(2);
    scroll_en = 1; scroll_dir = 0;
    ticks(6);
    check("left_step1", 128'(mat_w[0][7:0]), 128'(8'h80));
    ticks(28);
    check("left_wrap", 128'(mat_w[0][7:0]), 128'(8'h01));
    scroll_dir = 1;
    ticks(24);
    scroll_en = 0;
    ticks(30);

    // last write wins, untouched rows carry over, held request during COMMIT
    wr(3'd2, 8'hAA, 8'h11, 1'b0, nw);
    wr(3'd2, 8'h55, 8'h22, 1'b0, nw);
    wr(3'd5, 8'h0F, 8'hF0, 1'b1, nw);
    wr(3'd6, 8'h00, 8'h00, 1'b0, nw);
    check("held_during_commit", 128'(nw), 128'(2));
    tick();
    check("row2_red",   128'(mat_w[0][23:16]),  128'(8'h55));
    check("row2_green", 128'(mat_w[0][87:80]),  128'(8'h22));
    check("row0_carry", 128'(mat_w[0][7:0]),    128'(8'h01));
    check("row5_red",   128'(mat_w[0][47:40]),  128'(8'h0F));

    // reset asserted during COMMIT clears Mat immediately
    wr(3'd3, 8'hFF, 8'hFF, 1'b1, nw);
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("midcommit_mat", mat_w[k], 128'(0));
      check("midcommit_rdy", 128'(rdy_w[k]), 128'(1));
    end
    @(negedge clk_1KHz);
    rst_n = 1;
    tick();

    // randomized traffic: writes, commits, scroll toggling, direction changes
    for (int i = 0; i < 3000; i++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_row   = 3'($urandom_range(0, 7));
      wr_red   = 8'($urandom);
      wr_green = 8'($urandom);
      wr_last  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 19) == 0) scroll_en  = ~scroll_en;
      if ($urandom_range(0, 29) == 0) scroll_dir = ~scroll_dir;
      if (i == 100) scroll_en = 1;
      tick();
    end
    wr_valid = 0; wr_last = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mat_frame_scroller.md
Name: mat_frame_scroller

Overview:
Upstream frame source for the 8x8 bicolour matrix scanner. It accepts row writes into a back buffer and commits a whole frame atomically into a front buffer. It optionally rotates every row horizontally at a programmable step rate. It drives the 128-bit Mat bus the scanner consumes, using the same layout: red row r in Mat[8r+7:8r], green row r in Mat[64+8r+7:64+8r], and column c in bit c of each row byte.

Parameters:
STEP_TICKS, 250, clock cycles per scroll step (1 kHz / 250 = 4 steps/s); legal range 1..65535.

Ports:
clk_1KHz  in  1  system clock, shared with the scanner
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  row write request
wr_ready  out  1  block can accept a write this cycle
wr_row  in  3  target row index 0..7
wr_red  in  8  red bits for the row, bit c = column c
wr_green  in  8  green bits for the row
wr_last  in  1  final write of a frame; triggers commit
scroll_en  in  1  enable horizontal rotation
scroll_dir  in  1  0 = rotate left (content moves toward column 0), 1 = rotate right
Mat  out  128  registered frame to the scanner
commit_done  out  1  one-cycle pulse on the first cycle Mat shows a newly committed frame

Behaviour:
- Reset (async assert, sync release): back buffer = 0, front buffer = 0, offset = 0, divider = 0, state = ACCEPT, Mat = 0, commit_done = 0, wr_ready = 1.
- State machine:
  - ACCEPT: wr_ready = 1. A write is accepted when wr_valid && wr_ready; it updates back buffer row wr_row at that edge. If wr_last is also set, go to COMMIT.
  - COMMIT: lasts exactly 1 cycle with wr_ready = 0. At its closing edge: front = back, offset = 0, divider = 0, and the state returns to ACCEPT.
- Commit latency: wr_last is accepted at edge N, so front and offset update at edge N+1. Mat shows the new frame after edge N+2, and commit_done is high for the cycle between edges N+2 and N+3.
- Back buffer contents persist after a commit. Rows not rewritten carry over into the next frame.
- Rewriting the same row before commit: the last write wins.
- wr_valid while wr_ready = 0 is ignored; the source must hold the request.
- Divider and offset:
  - With scroll_en = 1, divider counts 0..STEP_TICKS-1. On the wrap cycle, offset advances by 1 mod 8, wrapping 7 -> 0.
  - With scroll_en = 0, divider is held at 0 and offset holds its value. Re-enabling starts a full STEP_TICKS interval.
  - STEP_TICKS = 1 advances offset every cycle.
- Commit vs scroll step in the same cycle: commit wins. offset = 0, divider = 0, and the step is lost.
- Rotation, evaluated per row for both colours:
  - dir = 0: Mat bit c = front bit (c + offset) mod 8.
  - dir = 1: Mat bit c = front bit (c − offset) mod 8.
- Mat is registered and reloaded every cycle from front, offset and scroll_dir, so it lags those by one cycle.
- Changing scroll_dir mid-scroll keeps the offset value; only the mapping changes on the next Mat update.
- Reset mid-frame discards any partial back-buffer writes; a pending COMMIT is aborted.

Decomposition:
- Package mat_pkg holds:
  - constants MAT_ROWS = 8, MAT_COLS = 8, MAT_W = 128, GREEN_BASE = 64;
  - a row-index typedef (3 bits);
  - an enum for the state: ACCEPT, COMMIT.
- One natural sub-module, mat_row_rotate: combinational 8-bit rotate by 3-bit offset and direction. It is instantiated 16 times (8 red rows, 8 green rows).
- Divider, FSM and buffers stay in the top module.

Test Plan:
- Reset with all inputs 0 -> Mat = 0, wr_ready = 1, commit_done = 0. Asserting rst_n low mid-COMMIT -> Mat = 0 immediately.
- Write rows 0..7 with red = 8'h01 << r and green = 0, wr_last on row 7, scroll_en = 0 -> wr_ready low 1 cycle. Two cycles after the last accept, Mat red row r = 1 << r, Mat[127:64] = 0, and commit_done pulses once.
- STEP_TICKS = 4; frame red row 0 = 8'h01, others 0; scroll_en = 1, dir = 0 -> row 0 reads 8'h01, then 8'h80, 8'h40 … changing every 4 cycles. After 8 steps it returns to 8'h01 (wrap check).
- Same frame with dir = 1 -> row 0 sequence 8'h01, 8'h02, 8'h04 …. Dropping scroll_en holds the current value indefinitely.
- Commit lands on the same edge as a scheduled step (STEP_TICKS = 3, offset = 5) -> offset = 0 and the new frame is shown unrotated. The next step occurs 3 cycles later.
- Write rows 2 and 2 again with different data, then wr_last on row 5 -> committed row 2 holds the second write. Rows 0, 1, 3, 4, 6, 7 keep the previous frame's values. A wr_valid held during COMMIT is accepted one cycle later.
